alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator-side driver for the 8-bit combinational ALU: accepts {A,B,Op,c_in} commands over
//  a valid/ready interface, drives the ALU operand/opcode pins, waits a settle window, captures R
//  and returns it with a tag over a valid/ready response interface. Replaces ad-hoc stimulus
//  sequencing and sits between a command source and the ALU datapath.
// PARAMETERS
//  WIDTH         8   operand/result width (matches ALU)
//  SETTLE_CYC    2   cycles ALU inputs are held stable before R is sampled (>=1)
//  TAG_W         4   width of wrap-around transaction tag
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept command
//  cmd_a      in   WIDTH  operand A
//  cmd_b      in   WIDTH  operand B
//  cmd_op     in   3      opcode, 0..6 legal, 7 illegal
//  cmd_cin    in   1      carry-in
//  alu_a      out  WIDTH  to ALU A
//  alu_b      out  WIDTH  to ALU B
//  alu_op     out  3      to ALU Op
//  alu_cin    out  1      to ALU c_in
//  alu_r      in   WIDTH  from ALU R
//  rsp_valid  out  1      response present
//  rsp_ready  in   1      consumer accepts response
//  rsp_r      out  WIDTH  captured result (0 when rsp_err)
//  rsp_tag    out  TAG_W  tag of the command this response answers
//  rsp_err    out  1      command carried illegal opcode 7
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; cmd_ready=1 once released; rsp_valid=0, rsp_r=0,
//    rsp_tag=0, rsp_err=0; alu_a/b/op/cin=0; tag counter=0; settle counter=0.
//  - States: IDLE -> SETTLE -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready: register operands onto alu_* (visible next cycle),
//    latch tag, load settle counter=SETTLE_CYC-1. Legal op -> SETTLE. Op 7 -> RESP directly with
//    rsp_err=1, rsp_r=0, alu_* unchanged (ALU not driven with illegal code).
//  - SETTLE: cmd_ready=0; count down; at 0 sample alu_r into rsp_r, rsp_err=0 -> RESP.
//  - RESP: rsp_valid=1, outputs stable until rsp_valid&rsp_ready; on handshake tag counter
//    increments (mod 2^TAG_W, wraps 15->0 at default) -> IDLE. No back-to-back overlap:
//    cmd_ready deasserts from acceptance until response handshake completes.
//  - Latency legal op: accept at edge N -> rsp_valid high from edge N+SETTLE_CYC+1.
//    Illegal op: rsp_valid high from edge N+1.
//  - alu_* hold last issued values across RESP/IDLE (no glitching of ALU inputs).
//  - rsp_ready held low: response stalls indefinitely, no data loss, no new command accepted.
//  - cmd_valid without ready: ignored; a command may be withdrawn while cmd_ready=0.
//  - rst_n asserted mid-operation (any state): immediate return to reset values, pending
//    response discarded, tag restarts at 0.
// STRUCTURE
//  - Shared package: state encoding (ST_IDLE, ST_SETTLE, ST_RESP), OP_ILLEGAL=3'd7,
//    OP_MAX_LEGAL=3'd6, default WIDTH.
//  - Single module; no sub-module needed. Tag counter and settle counter are inline registers.
// TESTING (bench instantiates real ALU on alu_* / alu_r)
//  1 A=8'h14,B=8'h06,Op=0,cin=0, rsp_ready=1 -> one rsp, rsp_r==ALU(op0) ref, tag=0, err=0,
//    rsp_valid exactly SETTLE_CYC+1 cycles after accept.
//  2 Ops 1..6 on A=8'h14,B=8'h06,cin=1 back-to-back -> six rsp, tags 1..6, each rsp_r matches
//    ALU reference model; cmd_ready low between accept and rsp handshake.
//  3 Op=7 -> rsp_err=1, rsp_r=0, response one cycle after accept, alu_op unchanged from prior.
//  4 rsp_ready held 0 for 20 cycles -> rsp_valid/rsp_r/rsp_tag stable, cmd_ready=0 throughout;
//    release -> handshake, return to IDLE.
//  5 Issue 17 commands -> rsp_tag sequence 0..15 then 0 (wrap).
//  6 Assert rst_n=0 in SETTLE -> all outputs reset asynchronously; next command gets tag 0.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg: shared state encoding and opcode limits for the ALU command sequencer.
package alu_cmd_sequencer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_e;
  localparam logic [2:0] OP_ILLEGAL   = 3'd7;
  localparam logic [2:0] OP_MAX_LEGAL = 3'd6;
  localparam int         DEF_WIDTH    = 8;
endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: drives the ALU from a command stream, waits for settling and returns the tagged result.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SETTLE_CYC = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [2:0]       op_q;
  logic             cin_q, err_q;
  logic [TAG_W-1:0] rtag_q;

  assign cmd_ready = state_q == ST_IDLE;
  assign rsp_valid = state_q == ST_RESP;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_cin   = cin_q;
  assign rsp_r     = r_q;
  assign rsp_tag   = rtag_q;
  assign rsp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      r_q     <= '0;
      err_q   <= 1'b0;
      rtag_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          rtag_q <= tag_q;
          cnt_q  <= CW'(SETTLE_CYC - 1);
          // An illegal opcode never reaches the ALU pins; it is answered straight away.
          if (cmd_op <= OP_MAX_LEGAL) begin
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            op_q    <= cmd_op;
            cin_q   <= cmd_cin;
            state_q <= ST_SETTLE;
          end else begin
            r_q     <= '0;
            err_q   <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_SETTLE: if (cnt_q == '0) begin
          r_q     <= alu_r;
          err_q   <= 1'b0;
          state_q <= ST_RESP;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
        ST_RESP: if (rsp_ready) begin
          tag_q   <= tag_q + TAG_W'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: randomized and directed checks of the sequencer against a transaction-level model.
module tb_alu_cmd_sequencer;
  localparam int S = 2;

  logic       clk = 0, rst_n = 0, cmd_valid = 0, cmd_cin = 0, rsp_ready = 0;
  logic [7:0] cmd_a = 0, cmd_b = 0;
  logic [2:0] cmd_op = 0;
  logic       cmd_ready, alu_cin, rsp_valid, rsp_err;
  logic [7:0] alu_a, alu_b, alu_r, rsp_r;
  logic [2:0] alu_op;
  logic [3:0] rsp_tag;

  int total = 0, bad = 0;
  int mtag = 0;
  logic [7:0] last_a = 0, last_b = 0;
  logic [2:0] last_op = 0;
  logic       last_cin = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, b, input logic [2:0] op, input logic cin);
    case (op)
      3'd0:    return a + b + 8'(cin);
      3'd1:    return a - b - 8'(cin);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {a[6:0], cin};
      3'd6:    return ~a;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_r = alu_ref(alu_a, alu_b, alu_op, alu_cin);

  alu_cmd_sequencer #(.WIDTH(8), .SETTLE_CYC(S), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin), .alu_r(alu_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", rsp_valid, 0);
    check("rst_r", rsp_r, 0);
    check("rst_tag", rsp_tag, 0);
    check("rst_err", rsp_err, 0);
    check("rst_alu", {alu_a, alu_b, alu_op, alu_cin}, 0);
  endtask

  task automatic send(input logic [7:0] a, b, input logic [2:0] op, input logic cin);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_cin = cin;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_wait", n < 50, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0; cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 3'($urandom); cmd_cin = 1'($urandom);
  endtask

  task automatic run_cmd(input logic [7:0] a, b, input logic [2:0] op, input logic cin, input int stall);
    int lat = 1;
    logic       ee = (op == 3'd7);
    logic [7:0] er = ee ? 8'h00 : alu_ref(a, b, op, cin);
    send(a, b, op, cin);
    check("busy_ready", cmd_ready, 0);
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    check("latency", lat, ee ? 1 : S + 1);
    check("rsp_r", rsp_r, er);
    check("rsp_tag", rsp_tag, mtag);
    check("rsp_err", rsp_err, ee);
    if (!ee) begin last_a = a; last_b = b; last_op = op; last_cin = cin; end
    check("alu_pins", {alu_a, alu_b, alu_op, alu_cin}, {last_a, last_b, last_op, last_cin});
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1; cmd_op = 3'($urandom_range(0, 6));
      @(negedge clk);
      check("stall_ready", cmd_ready, 0);
      check("stall_rsp", {rsp_valid, rsp_r, rsp_tag, rsp_err}, {1'b1, er, 4'(mtag), ee});
    end
    cmd_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("done_valid", rsp_valid, 0);
    check("idle_ready", cmd_ready, 1);
    check("alu_hold", {alu_a, alu_b, alu_op, alu_cin}, {last_a, last_b, last_op, last_cin});
    mtag = (mtag + 1) % 16;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    run_cmd(8'h14, 8'h06, 3'd0, 1'b0, 0);
    for (int op = 1; op <= 6; op++) run_cmd(8'h14, 8'h06, 3'(op), 1'b1, 0);
    run_cmd(8'h14, 8'h06, 3'd7, 1'b0, 0);
    run_cmd(8'hA5, 8'h3C, 3'd1, 1'b0, 20);
    for (int i = 0; i < 17; i++) run_cmd(8'(i * 13 + 7), 8'(i * 29), 3'(i % 8), 1'(i), i % 2);
    for (int i = 0; i < 30; i++)
      run_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3));
    send(8'hFF, 8'h01, 3'd0, 1'b1);
    #1 rst_n = 0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1;
    mtag = 0; last_a = 0; last_b = 0; last_op = 0; last_cin = 0;
    run_cmd(8'h33, 8'h44, 3'd4, 1'b0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
